// File: rtl/cache_opr_seq_pkg.sv
// cache_opr_pkg: shared types, command codes and decode helpers for the
// cache operation sequencer (cache_opr_seq).
package cache_opr_pkg;

  localparam int NUM_OPR = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_ILLEGAL_CMD = 2'd1,
    ERR_TIMEOUT     = 2'd2,
    ERR_ABORT       = 2'd3
  } err_code_e;

  // Trace command codes grouped by the stage mask they select.
  localparam logic [3:0] CMD_FULL_A = 4'd0;
  localparam logic [3:0] CMD_FULL_B = 4'd1;
  localparam logic [3:0] CMD_FULL_C = 4'd2;
  localparam logic [3:0] CMD_PART_A = 4'd3;
  localparam logic [3:0] CMD_PART_B = 4'd4;
  localparam logic [3:0] CMD_PART_C = 4'd5;
  localparam logic [3:0] CMD_PART_D = 4'd6;
  localparam logic [3:0] CMD_TAIL   = 4'd8;
  localparam logic [3:0] CMD_TAG    = 4'd9;

  typedef struct packed {
    logic               legal;
    logic [NUM_OPR-1:0] mask;
  } mask_dec_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } stage_sel_t;

  // Map a command code to its stage mask; unknown codes are flagged illegal.
  function automatic mask_dec_t cmd_to_mask(input logic [3:0] cmd);
    mask_dec_t r;
    r.legal = 1'b1;
    r.mask  = 8'h00;
    case (cmd)
      CMD_FULL_A, CMD_FULL_B, CMD_FULL_C:             r.mask = 8'hFF;
      CMD_PART_A, CMD_PART_B, CMD_PART_C, CMD_PART_D: r.mask = 8'h65;
      CMD_TAIL:                                       r.mask = 8'hC0;
      CMD_TAG:                                        r.mask = 8'h01;
      default:                                        r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // Lowest set mask bit strictly above idx.
  function automatic stage_sel_t next_stage(input logic [NUM_OPR-1:0] mask,
                                            input logic [2:0] idx);
    stage_sel_t r;
    r.found = 1'b0;
    r.idx   = 3'd0;
    for (int i = NUM_OPR - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(idx))) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_opr_seq_if.sv
// cache_opr_seq_if: command handshake from the trace parser plus the
// start/done strobes to the operation stages.
interface cache_opr_seq_if #(parameter int ADDR_W = 32);
  import cache_opr_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [3:0]         req_cmd;
  logic [ADDR_W-1:0]  req_addr;
  logic [NUM_OPR-1:0] opr_start;
  logic [NUM_OPR-1:0] opr_done;

  modport slave (
    input  req_valid, req_cmd, req_addr, opr_done,
    output req_ready, opr_start
  );

  modport master (
    output req_valid, req_cmd, req_addr, opr_done,
    input  req_ready, opr_start
  );
endinterface

// File: rtl/cache_opr_seq_watchdog.sv
// cache_opr_watchdog: counts consecutive enabled cycles; expired is high
// once TIMEOUT_CYC-1 cycles have been counted, so the TIMEOUT_CYC-th
// enabled cycle is the one that sees it.
module cache_opr_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt_r;

  assign expired = (cnt_r == CW'(TIMEOUT_CYC - 1));

  // Wait-cycle counter, cleared on each new stage issue, stops at expiry.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/cache_opr_seq.sv
// cache_opr_seq: accepts one trace command, pulses opr_start for each
// enabled stage in ascending order waiting for each done, then reports
// seq_done or seq_err. Optional feature macro: CACHE_OPR_SEQ_WATCHDOG_EN
// builds the per-stage wait watchdog and the TIMEOUT error.
module cache_opr_seq
  import cache_opr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rstb,
  cache_opr_seq_if.slave    bus,
  input  logic              abort,
  output logic [3:0]        cur_cmd,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [1:0]        err_code,
  output logic [2:0]        err_stage
);
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("cache_opr_seq: TIMEOUT_CYC must be at least 2");
  end

  state_e             state_r;
  logic [2:0]         idx_r;
  logic [NUM_OPR-1:0] mask_r;
  logic [3:0]         cur_cmd_r;
  logic [ADDR_W-1:0]  cur_addr_r;
  err_code_e          err_code_r;
  logic [2:0]         err_stage_r;

  mask_dec_t          dec_s;
  stage_sel_t         first_s;
  stage_sel_t         next_s;
  logic               done_hit_s;
  logic [NUM_OPR-1:0] start_s;

`ifdef CACHE_OPR_SEQ_WATCHDOG_EN
  logic wd_expired_s;

  cache_opr_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rstb    (rstb),
    .clear   (state_r == ISSUE),
    .enable  ((state_r == WAIT) && !abort && !done_hit_s),
    .expired (wd_expired_s)
  );
`endif

  // Command decode and next-stage lookup for the FSM.
  always_comb begin
    dec_s      = cmd_to_mask(bus.req_cmd);
    next_s     = next_stage(mask_r, idx_r);
    done_hit_s = bus.opr_done[idx_r];
    if (dec_s.mask[0]) begin
      first_s = '{found: 1'b1, idx: 3'd0};
    end else begin
      first_s = next_stage(dec_s.mask, 3'd0);
    end
  end

  // One-hot start pulse decoded from the registered state and index.
  always_comb begin
    start_s = '0;
    if (state_r == ISSUE) begin
      start_s[idx_r] = 1'b1;
    end else begin
      start_s = '0;
    end
  end

  assign bus.opr_start = start_s;
  assign bus.req_ready = (state_r == IDLE);
  assign busy          = (state_r != IDLE);
  assign seq_done      = (state_r == DONE);
  assign seq_err       = (state_r == ERR);
  assign cur_cmd       = cur_cmd_r;
  assign cur_addr      = cur_addr_r;
  assign err_code      = err_code_r;
  assign err_stage     = err_stage_r;

  // Sequencer FSM: accept, issue/wait per stage, then report.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r     <= IDLE;
      idx_r       <= 3'd0;
      mask_r      <= '0;
      cur_cmd_r   <= 4'd0;
      cur_addr_r  <= '0;
      err_code_r  <= ERR_NONE;
      err_stage_r <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            cur_cmd_r   <= bus.req_cmd;
            cur_addr_r  <= bus.req_addr;
            mask_r      <= dec_s.mask;
            err_stage_r <= 3'd0;
            if (dec_s.legal) begin
              idx_r      <= first_s.idx;
              err_code_r <= ERR_NONE;
              state_r    <= ISSUE;
            end else begin
              err_code_r <= ERR_ILLEGAL_CMD;
              state_r    <= ERR;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (abort) begin
            err_code_r  <= ERR_ABORT;
            err_stage_r <= idx_r;
            state_r     <= ERR;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            err_code_r  <= ERR_ABORT;
            err_stage_r <= idx_r;
            state_r     <= ERR;
          end else if (done_hit_s) begin
            if (next_s.found) begin
              idx_r   <= next_s.idx;
              state_r <= ISSUE;
            end else begin
              state_r <= DONE;
            end
          end
`ifdef CACHE_OPR_SEQ_WATCHDOG_EN
          else if (wd_expired_s) begin
            err_code_r  <= ERR_TIMEOUT;
            err_stage_r <= idx_r;
            state_r     <= ERR;
          end
`endif
          else begin
            state_r <= WAIT;
          end
        end
        DONE:    state_r <= IDLE;
        ERR:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule
